am_demod: RTL and testbench

AM_DEMOD -- requirements
Module: am_demod

---
 rtl/am_demod.sv | 241 ++++++++++++++++++++++++
 tb/tb_am_demod.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_demod.sv
// ---------------------------------------------------------------------------
// am_demod -- envelope (AM) demodulator with decimation, DC removal, gain,
// saturation counting, sigma-delta audio output and a Wishbone register port.
//
// Pipeline (one register per stage):
//    stage 1 : |i_sample| captured on each i_ce
//    stage 2 : integrate-and-dump over R = 2^LGDECIMATE samples -> env
//    DC      : ac = env - (avg >> DC_SHIFT), leaky average update
//    gain    : o_audio = sat16((ac * gain) >>> 8), o_audio_valid pulse
//
// Ports:
//    i_clk, i_reset_n       system clock / asynchronous active-low reset
//    i_ce, i_sample         RF sample strobe and signed IW-bit sample
//    i_wb_*                 Wishbone slave inputs (i_wb_sel ignored)
//    o_wb_stall/ack/data    Wishbone slave outputs (never stalls)
//    o_audio_valid          one-clock pulse per decimated audio sample
//    o_audio                signed 16-bit audio, held between pulses
//    o_pwm                  first-order sigma-delta bit of o_audio
//
// Registers:
//    0 RW  [15:0] gain (0x0100 = unity), [30] dc_bypass, [31] filter_reset
//    1 RO  {16'h0, o_audio}
//    2 RW  {16'h0, sat_count}; any write clears
//    3 RO  {20'h0, env[11:0]}
// ---------------------------------------------------------------------------
module am_demod #(
   parameter int IW         = 12,
   parameter int LGDECIMATE = 6,
   parameter int DC_SHIFT   = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_ce,
   input  logic signed [IW-1:0] i_sample,
   input  logic                 i_wb_cyc,
   input  logic                 i_wb_stb,
   input  logic                 i_wb_we,
   input  logic [1:0]           i_wb_addr,
   input  logic [31:0]          i_wb_data,
   input  logic [3:0]           i_wb_sel,
   output logic                 o_wb_stall,
   output logic                 o_wb_ack,
   output logic [31:0]          o_wb_data,
   output logic                 o_audio_valid,
   output logic signed [15:0]   o_audio,
   output logic                 o_pwm
);

   localparam int AW = IW + LGDECIMATE;
   localparam int VW = IW + DC_SHIFT;
   localparam int PW = IW + 17;

   localparam logic signed [PW-1:0] AUD_MAX = PW'(32767);
   localparam logic signed [PW-1:0] AUD_MIN = PW'(-32768);

   // Register-port decode
   logic wb_write;
   logic ctrl_write;
   logic filter_reset;
   logic sat_clear;

   assign wb_write     = i_wb_cyc & i_wb_stb & i_wb_we;
   assign ctrl_write   = wb_write && (i_wb_addr == 2'd0);
   assign filter_reset = ctrl_write & i_wb_data[31];
   assign sat_clear    = wb_write && (i_wb_addr == 2'd2);

   assign o_wb_stall = 1'b0;

   logic unused_wb;
   assign unused_wb = &{1'b0, i_wb_sel, i_wb_data[29:16]};

   logic [15:0] gain;
   logic        dc_bypass;

   // Control register; filter_reset is not stored, it acts only on the write clock
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         gain      <= 16'h0100;
         dc_bypass <= 1'b0;
      end else if (ctrl_write) begin
         gain      <= i_wb_data[15:0];
         dc_bypass <= i_wb_data[30];
      end
   end

   // Stage 1: magnitude. Two's-complement negation read as unsigned maps
   // the most negative sample to 2^(IW-1) without wrapping.
   logic [IW-1:0] abs_sample;
   logic [IW-1:0] mag;
   logic          mag_valid;

   assign abs_sample = i_sample[IW-1] ? (~$unsigned(i_sample) + IW'(1))
                                      : $unsigned(i_sample);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         mag       <= '0;
         mag_valid <= 1'b0;
      end else begin
         if (i_ce)
            mag <= abs_sample;
         mag_valid <= i_ce & ~filter_reset;
      end
   end

   // Stage 2: integrate-and-dump. The block's last sample is folded into
   // the dumped sum, so the accumulator starts the next block from zero
   // and no sample is lost across the boundary.
   logic [AW-1:0]         acc;
   logic [AW-1:0]         acc_sum;
   logic [LGDECIMATE-1:0] count;
   logic [IW-1:0]         env;
   logic                  env_valid;

   assign acc_sum = acc + {{LGDECIMATE{1'b0}}, mag};

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         acc       <= '0;
         count     <= '0;
         env       <= '0;
         env_valid <= 1'b0;
      end else if (filter_reset) begin
         acc       <= '0;
         count     <= '0;
         env_valid <= 1'b0;
      end else begin
         env_valid <= 1'b0;
         if (mag_valid) begin
            count <= count + LGDECIMATE'(1);
            if (&count) begin
               env       <= acc_sum[AW-1:LGDECIMATE];
               acc       <= '0;
               env_valid <= 1'b1;
            end else begin
               acc <= acc_sum;
            end
         end
      end
   end

   // DC tracker: leaky average of env; dc is taken before the update
   logic [VW-1:0]        avg;
   logic [IW-1:0]        dc;
   logic signed [IW:0]   ac_next;
   logic signed [IW:0]   ac;
   logic                 ac_valid;

   assign dc      = avg[VW-1:DC_SHIFT];
   assign ac_next = dc_bypass ? $signed({1'b0, env})
                              : $signed({1'b0, env} - {1'b0, dc});

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         avg      <= '0;
         ac       <= '0;
         ac_valid <= 1'b0;
      end else if (filter_reset) begin
         avg      <= '0;
         ac_valid <= 1'b0;
      end else begin
         ac_valid <= env_valid;
         if (env_valid) begin
            ac  <= ac_next;
            avg <= avg + VW'(env) - VW'(dc);
         end
      end
   end

   // Gain and saturation to the 16-bit audio range
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] scaled;
   logic                 sat_hi;
   logic                 sat_lo;
   logic signed [15:0]   audio_next;
   logic [15:0]          sat_count;

   assign prod       = ac * $signed(gain);
   assign scaled     = prod >>> 8;
   assign sat_hi     = scaled > AUD_MAX;
   assign sat_lo     = scaled < AUD_MIN;
   assign audio_next = sat_hi ? 16'sh7FFF :
                       sat_lo ? 16'sh8000 : scaled[15:0];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_audio       <= '0;
         o_audio_valid <= 1'b0;
      end else if (filter_reset) begin
         o_audio_valid <= 1'b0;
      end else begin
         o_audio_valid <= ac_valid;
         if (ac_valid)
            o_audio <= audio_next;
      end
   end

   // Saturation counter; a register write wins over a same-clock saturation
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)
         sat_count <= '0;
      else if (sat_clear)
         sat_count <= '0;
      else if (ac_valid && (sat_hi || sat_lo) && (sat_count != 16'hFFFF))
         sat_count <= sat_count + 16'd1;
   end

   // Sigma-delta: offset-binary audio into a 16-bit phase accumulator;
   // the carry out is the density-modulated output bit
   logic [16:0] integ;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         integ <= '0;
         o_pwm <= 1'b0;
      end else begin
         integ <= {1'b0, integ[15:0]} + {1'b0, ~o_audio[15], o_audio[14:0]};
         o_pwm <= integ[16];
      end
   end

   // Read mux, registered every clock
   logic [11:0] env_12;
   assign env_12 = 12'(env);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_wb_ack  <= 1'b0;
         o_wb_data <= '0;
      end else begin
         o_wb_ack <= i_wb_stb;
         case (i_wb_addr)
            2'd0:    o_wb_data <= {1'b0, dc_bypass, 14'h0, gain};
            2'd1:    o_wb_data <= {16'h0, o_audio};
            2'd2:    o_wb_data <= {16'h0, sat_count};
            default: o_wb_data <= {20'h0, env_12};
         endcase
      end
   end

endmodule

// File: tb/tb_am_demod.sv
// ---------------------------------------------------------------------------
// tb_am_demod -- self-checking bench for am_demod. Inputs change on the
// falling edge; outputs are sampled on the falling edge. A behavioural model
// (block sums, leaky average, clamp) predicts every audio sample and the
// falling edge on which its o_audio_valid pulse must be seen.
// ---------------------------------------------------------------------------
module tb_am_demod;

   localparam int R = 64;

   logic               i_clk = 1'b0;
   logic               i_reset_n = 1'b0;
   logic               i_ce = 1'b0;
   logic signed [11:0] i_sample = '0;
   logic               i_wb_cyc = 1'b0;
   logic               i_wb_stb = 1'b0;
   logic               i_wb_we = 1'b0;
   logic [1:0]         i_wb_addr = '0;
   logic [31:0]        i_wb_data = '0;
   logic [3:0]         i_wb_sel = 4'hF;
   logic               o_wb_stall;
   logic               o_wb_ack;
   logic [31:0]        o_wb_data;
   logic               o_audio_valid;
   logic signed [15:0] o_audio;
   logic               o_pwm;

   am_demod #(.IW(12), .LGDECIMATE(6), .DC_SHIFT(8)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_ce(i_ce), .i_sample(i_sample),
      .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
      .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
      .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
      .o_audio_valid(o_audio_valid), .o_audio(o_audio), .o_pwm(o_pwm)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int assertCount = 0;
   int failCount   = 0;

   task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Behavioural model state
   typedef struct { int due; int audio; } exp_t;
   exp_t exp_q[$];
   int   model_block[$];
   int   model_avg = 0;
   int   model_gain = 256;
   bit   model_bypass = 1'b0;
   int   model_sat = 0;
   int   model_env = 0;

   int   audio_hist[$];
   int   valid_count = 0;

   // Closes a block: average of magnitudes, DC removal, gain, clamp.
   // A sample driven now is clocked in next edge; audio appears 4 clocks later.
   task automatic modelFinishBlock();
      int sum, dc, ac, scaled, gs, audio;
      sum = 0;
      foreach (model_block[i]) sum += model_block[i];
      model_env = sum / R;
      dc = model_avg / 256;
      ac = model_bypass ? model_env : model_env - dc;
      model_avg = model_avg + model_env - dc;
      gs = (model_gain >= 32768) ? model_gain - 65536 : model_gain;
      scaled = (ac * gs) >>> 8;
      if (scaled > 32767) begin
         audio = 32767;
         if (model_sat < 65535) model_sat++;
      end else if (scaled < -32768) begin
         audio = -32768;
         if (model_sat < 65535) model_sat++;
      end else begin
         audio = scaled;
      end
      exp_q.push_back('{due: cyc + 4, audio: audio});
      model_block.delete();
   endtask

   // Called just after a falling edge; leaves just after a falling edge
   task automatic applyStimulus(input int value, input int gap);
      i_ce = 1'b1;
      i_sample = 12'(value);
      model_block.push_back(value < 0 ? -value : value);
      if (model_block.size() == R) modelFinishBlock();
      @(negedge i_clk);
      i_ce = 1'b0;
      repeat (gap) @(negedge i_clk);
   endtask

   task automatic wbWrite(input logic [1:0] addr, input logic [31:0] data);
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
      i_wb_addr = addr; i_wb_data = data;
      if (addr == 2'd0) begin
         model_gain = int'(data[15:0]);
         model_bypass = data[30];
         if (data[31]) begin
            model_block.delete();
            model_avg = 0;
         end
      end else if (addr == 2'd2) begin
         model_sat = 0;
      end
      @(negedge i_clk);
      checkOutput("wb_write_ack", o_wb_ack, 1);
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
   endtask

   task automatic wbRead(input logic [1:0] addr, output logic [31:0] data);
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = addr;
      @(negedge i_clk);
      checkOutput("wb_read_ack", o_wb_ack, 1);
      data = o_wb_data;
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
   endtask

   task automatic drain();
      repeat (8) @(negedge i_clk);
   endtask

   // Output monitor: every pulse must match the head of the expectation queue
   always @(negedge i_clk) begin
      if (i_reset_n) begin
         if (o_audio_valid === 1'b1) begin
            valid_count++;
            audio_hist.push_back(int'(o_audio));
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_valid", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checkOutput("valid_latency", cyc, e.due);
               checkOutput("audio_value", o_audio, e.audio);
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            checkOutput("missed_valid", 0, 1);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      int ones, vc, n, sparse_val, g;
      bit bp;

      // Reset state
      @(negedge i_clk);
      checkOutput("rst_audio", o_audio, 0);
      checkOutput("rst_valid", o_audio_valid, 0);
      checkOutput("rst_pwm", o_pwm, 0);
      checkOutput("rst_ack", o_wb_ack, 0);
      checkOutput("rst_wb_data", o_wb_data, 0);
      checkOutput("wb_stall", o_wb_stall, 0);
      @(negedge i_clk);
      i_reset_n = 1'b1;

      // Silent audio -> 50% pwm density
      ones = 0;
      repeat (1024) begin
         @(negedge i_clk);
         ones += int'(o_pwm);
      end
      checkOutput("pwm_duty", (ones >= 511 && ones <= 513) ? 512 : ones, 512);

      wbRead(2'd0, rd); checkOutput("reset_ctrl_reg", rd, 32'h0000_0100);
      wbRead(2'd1, rd); checkOutput("reset_audio_reg", rd, 0);
      wbRead(2'd2, rd); checkOutput("reset_sat_reg", rd, 0);
      wbRead(2'd3, rd); checkOutput("reset_env_reg", rd, 0);

      // Bypass, unity gain, alternating +/-1000, dense strobes
      wbWrite(2'd0, 32'h4000_0100);
      vc = valid_count;
      for (int i = 0; i < 2 * R; i++) applyStimulus((i % 2) ? -1000 : 1000, 0);
      drain();
      checkOutput("alt_output_count", valid_count - vc, 2);
      checkOutput("alt_audio", audio_hist[$], 1000);

      // Randomized blocks: random gain (both signs), random bypass, random gaps
      for (int b = 0; b < 6; b++) begin
         g  = int'($urandom_range(0, 2047)) - 1024;
         bp = 1'($urandom_range(0, 1));
         wbWrite(2'd0, {1'b0, bp, 14'h0, 16'(g)});
         for (int i = 0; i < R; i++)
            applyStimulus(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 2)));
         drain();
      end
      wbRead(2'd2, rd); checkOutput("random_sat_count", rd, model_sat);
      wbRead(2'd3, rd); checkOutput("random_env_reg", rd, model_env);

      // DC tracking: constant envelope 1000 decays 1000, 997, ...
      wbWrite(2'd0, 32'h8000_0100);
      n = audio_hist.size();
      for (int i = 0; i < 3 * R; i++) applyStimulus(1000, 0);
      drain();
      checkOutput("dc_first", audio_hist[n], 1000);
      checkOutput("dc_second", audio_hist[n + 1], 997);
      checkOutput("dc_decaying", (audio_hist[n + 2] < audio_hist[n + 1]) ? 1 : 0, 1);

      // Saturation
      wbWrite(2'd2, 32'h0);
      wbWrite(2'd0, 32'hC000_7FFF);
      for (int i = 0; i < 2 * R; i++) applyStimulus(-2048, 0);
      drain();
      checkOutput("sat_audio", audio_hist[$], 32767);
      wbRead(2'd2, rd); checkOutput("sat_count", rd, 2);
      wbRead(2'd1, rd); checkOutput("audio_reg", rd, 32'h0000_7FFF);
      wbRead(2'd3, rd); checkOutput("env_reg", rd, 32'h0000_0800);
      wbWrite(2'd2, 32'h0);
      wbRead(2'd2, rd); checkOutput("sat_cleared", rd, 0);

      // Sparse strobes (1 in 5) must match dense strobes
      wbWrite(2'd0, 32'hC000_0100);
      for (int i = 0; i < R; i++) applyStimulus(500, 4);
      drain();
      sparse_val = audio_hist[$];
      checkOutput("sparse_audio", sparse_val, 500);
      for (int i = 0; i < R; i++) applyStimulus(500, 0);
      drain();
      checkOutput("sparse_equals_dense", audio_hist[$], sparse_val);

      // Filter reset mid-block discards the partial block
      for (int i = 0; i < 30; i++) applyStimulus(700, 0);
      wbWrite(2'd0, 32'hC000_0100);
      @(negedge i_clk);
      checkOutput("wb_ack_drop", o_wb_ack, 0);
      vc = valid_count;
      for (int i = 0; i < R - 1; i++) applyStimulus(700, 0);
      drain();
      checkOutput("no_early_output", valid_count - vc, 0);
      applyStimulus(700, 0);
      drain();
      checkOutput("after_filter_reset_count", valid_count - vc, 1);
      checkOutput("after_filter_reset_audio", audio_hist[$], 700);

      // Gain change mid-block applies to the whole next result
      for (int i = 0; i < R / 2; i++) applyStimulus(400, 0);
      wbWrite(2'd0, 32'h4000_0200);
      for (int i = 0; i < R / 2; i++) applyStimulus(-400, 1);
      drain();
      checkOutput("midblock_gain", audio_hist[$], 800);

      // Asynchronous reset mid-block
      for (int i = 0; i < 20; i++) applyStimulus(900, 0);
      @(posedge i_clk);
      #3;
      i_reset_n = 1'b0;
      #1;
      checkOutput("async_rst_audio", o_audio, 0);
      checkOutput("async_rst_valid", o_audio_valid, 0);
      checkOutput("async_rst_pwm", o_pwm, 0);
      checkOutput("async_rst_ack", o_wb_ack, 0);
      checkOutput("async_rst_wb_data", o_wb_data, 0);
      model_block.delete();
      model_avg = 0;
      model_gain = 256;
      model_bypass = 1'b0;
      model_sat = 0;
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      wbRead(2'd0, rd); checkOutput("post_rst_ctrl", rd, 32'h0000_0100);
      vc = valid_count;
      for (int i = 0; i < R - 1; i++) applyStimulus(300, 0);
      drain();
      checkOutput("post_rst_no_partial", valid_count - vc, 0);
      applyStimulus(300, 0);
      drain();
      checkOutput("post_rst_audio", audio_hist[$], 300);

      checkOutput("pending_outputs", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
